// File: rtl/mesi_mbus_arbiter_if.sv
// Bundle of the four coherence main-bus master request/ack lanes and the
// single downstream request channel toward the ISC broadcast logic.
interface mesi_mbus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CMD_WIDTH  = 3
);
    logic [3:0][CMD_WIDTH-1:0]  mbus_cmd;
    logic [3:0][ADDR_WIDTH-1:0] mbus_addr;
    logic [3:0]                 mbus_ack;

    logic                       out_valid;
    logic                       out_ready;
    logic [CMD_WIDTH-1:0]       out_cmd;
    logic [ADDR_WIDTH-1:0]      out_addr;
    logic [1:0]                 out_id;

    // Requesters and the downstream consumer as seen from outside the arbiter.
    modport master (
        output mbus_cmd, mbus_addr, out_ready,
        input  mbus_ack, out_valid, out_cmd, out_addr, out_id
    );

    modport slave (
        input  mbus_cmd, mbus_addr, out_ready,
        output mbus_ack, out_valid, out_cmd, out_addr, out_id
    );
endinterface

// File: rtl/mesi_mbus_arbiter.sv
// Four-master main-bus arbiter with a one-entry output register.
// Round-robin by default; define MBUS_ARB_FIXED_PRIO_EN for fixed priority (master 0 highest).
module mesi_mbus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int CMD_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    mesi_mbus_arbiter_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             ack_reg, ack_next;
    logic                   out_valid_reg, out_valid_next;
    logic [CMD_WIDTH-1:0]   out_cmd_reg, out_cmd_next;
    logic [ADDR_WIDTH-1:0]  out_addr_reg, out_addr_next;
    logic [1:0]             out_id_reg, out_id_next;

    logic [3:0]             req;
    logic                   slot_free;
    logic [1:0]             winner;
    logic                   winner_found;
    logic                   grant;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_req
            assign req[gi]      = |bus.mbus_cmd[gi];
            assign ack_next[gi] = grant && (winner == 2'(gi));
        end
    endgenerate

    assign slot_free = !out_valid_reg || bus.out_ready;

`ifdef MBUS_ARB_FIXED_PRIO_EN
    always_comb begin
        winner       = 2'd0;
        winner_found = |req;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                winner = 2'(i);
            end
        end
    end
`else
    logic [1:0] ptr_reg, ptr_next;
    logic [1:0] scan_idx;

    // Scan upward from the pointer, wrapping modulo 4; first requester wins.
    always_comb begin
        winner       = 2'd0;
        winner_found = 1'b0;
        scan_idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = ptr_reg + 2'(i);
            if (!winner_found && req[scan_idx]) begin
                winner       = scan_idx;
                winner_found = 1'b1;
            end
        end
    end

    assign ptr_next = grant ? (winner + 2'd1) : ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 2'd0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`endif

    // The winner's command is still visible during ACK, so only IDLE arbitrates.
    assign grant = (state_reg == IDLE) && winner_found && slot_free;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid_next = out_valid_reg;
        out_cmd_next   = out_cmd_reg;
        out_addr_next  = out_addr_reg;
        out_id_next    = out_id_reg;
        if (grant) begin
            out_valid_next = 1'b1;
            out_cmd_next   = bus.mbus_cmd[winner];
            out_addr_next  = bus.mbus_addr[winner];
            out_id_next    = winner;
        end else if (out_valid_reg && bus.out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ack_reg       <= 4'd0;
            out_valid_reg <= 1'b0;
            out_cmd_reg   <= '0;
            out_addr_reg  <= '0;
            out_id_reg    <= 2'd0;
        end else begin
            state_reg     <= state_next;
            ack_reg       <= ack_next;
            out_valid_reg <= out_valid_next;
            out_cmd_reg   <= out_cmd_next;
            out_addr_reg  <= out_addr_next;
            out_id_reg    <= out_id_next;
        end
    end

    assign bus.mbus_ack  = ack_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_cmd   = out_cmd_reg;
    assign bus.out_addr  = out_addr_reg;
    assign bus.out_id    = out_id_reg;

endmodule

// File: tb/tb_mesi_mbus_arbiter.sv
// Directed bench for mesi_mbus_arbiter: reset, single grant, rotation,
// backpressure, withdrawal and asynchronous reset during ACK.
module tb_mesi_mbus_arbiter;

    localparam int ADDR_WIDTH = 32;
    localparam int CMD_WIDTH  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mesi_mbus_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .CMD_WIDTH(CMD_WIDTH)) bus ();

    mesi_mbus_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .CMD_WIDTH(CMD_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        for (int k = 0; k < 4; k++) begin
            bus.mbus_cmd[k]  = '0;
            bus.mbus_addr[k] = '0;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        @(posedge clk); #1;
        total++; if (bus.mbus_ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b expected 0000", bus.mbus_ack); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        total++; if (bus.out_cmd !== 3'd0) begin bad++; $display("FAIL reset_cmd: got %0d expected 0", bus.out_cmd); end
        total++; if (bus.out_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h expected 0", bus.out_addr); end
        total++; if (bus.out_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d expected 0", bus.out_id); end
        $display("reset: ack=%b valid=%b id=%0d", bus.mbus_ack, bus.out_valid, bus.out_id);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [1:0] exp_id;
        do_reset();
        bus.out_ready    = 1'b1;
        bus.mbus_cmd[1]  = 3'd2;
        bus.mbus_addr[1] = 32'h0000_1000;
        @(posedge clk); #1;
        total++; if (bus.mbus_ack !== 4'b0010) begin bad++; $display("FAIL single_ack: got %b expected 0010", bus.mbus_ack); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
        total++; if (bus.out_cmd !== 3'd2) begin bad++; $display("FAIL single_cmd: got %0d expected 2", bus.out_cmd); end
        total++; if (bus.out_addr !== 32'h0000_1000) begin bad++; $display("FAIL single_addr: got %h expected 00001000", bus.out_addr); end
        total++; if (bus.out_id !== 2'd1) begin bad++; $display("FAIL single_id: got %0d expected 1", bus.out_id); end
        $display("single: grant id=%0d cmd=%0d addr=%h", bus.out_id, bus.out_cmd, bus.out_addr);
        bus.mbus_cmd[1] = 3'd0;
        @(posedge clk); #1;
        total++; if (bus.mbus_ack !== 4'b0000) begin bad++; $display("FAIL single_ack_drop: got %b expected 0000", bus.mbus_ack); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_transfer: got %b expected 0", bus.out_valid); end
        total++; if (bus.out_addr !== 32'h0000_1000) begin bad++; $display("FAIL single_addr_hold: got %h expected 00001000", bus.out_addr); end
        // Pointer is now 2: with 0 and 2 requesting, 2 wins in round-robin.
        bus.mbus_cmd[0]  = 3'd1;
        bus.mbus_addr[0] = 32'h0000_0040;
        bus.mbus_cmd[2]  = 3'd3;
        bus.mbus_addr[2] = 32'h0000_0080;
`ifdef MBUS_ARB_FIXED_PRIO_EN
        exp_id = 2'd0;
`else
        exp_id = 2'd2;
`endif
        @(posedge clk); #1;
        total++; if (bus.out_id !== exp_id) begin bad++; $display("FAIL single_ptr_id: got %0d expected %0d", bus.out_id, exp_id); end
        total++; if (bus.mbus_ack !== (4'b0001 << exp_id)) begin bad++; $display("FAIL single_ptr_ack: got %b expected %b", bus.mbus_ack, 4'b0001 << exp_id); end
        $display("single: follow-up grant id=%0d", bus.out_id);
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id;
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.mbus_cmd[k]  = 3'(k + 1);
            bus.mbus_addr[k] = 32'hA000_0000 + 32'(k);
        end
        for (int g = 0; g < 5; g++) begin
`ifdef MBUS_ARB_FIXED_PRIO_EN
            exp_id = 2'd0;
`else
            exp_id = 2'(g % 4);
`endif
            @(posedge clk); #1;
            total++; if (bus.mbus_ack !== (4'b0001 << exp_id)) begin bad++; $display("FAIL rr_ack[%0d]: got %b expected %b", g, bus.mbus_ack, 4'b0001 << exp_id); end
            total++; if (bus.out_id !== exp_id) begin bad++; $display("FAIL rr_id[%0d]: got %0d expected %0d", g, bus.out_id, exp_id); end
            total++; if (bus.out_cmd !== 3'(exp_id + 1)) begin bad++; $display("FAIL rr_cmd[%0d]: got %0d expected %0d", g, bus.out_cmd, exp_id + 1); end
            total++; if (bus.out_addr !== (32'hA000_0000 + 32'(exp_id))) begin bad++; $display("FAIL rr_addr[%0d]: got %h expected %h", g, bus.out_addr, 32'hA000_0000 + 32'(exp_id)); end
            $display("rr: grant %0d id=%0d ack=%b", g, bus.out_id, bus.mbus_ack);
            @(posedge clk); #1;
            total++; if (bus.mbus_ack !== 4'b0000) begin bad++; $display("FAIL rr_gap[%0d]: got %b expected 0000", g, bus.mbus_ack); end
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready    = 1'b0;
        bus.mbus_cmd[0]  = 3'd1;
        bus.mbus_addr[0] = 32'h0000_00A0;
        bus.mbus_cmd[2]  = 3'd5;
        bus.mbus_addr[2] = 32'h0000_00C0;
        @(posedge clk); #1;
        total++; if (bus.mbus_ack !== 4'b0001) begin bad++; $display("FAIL bp_ack0: got %b expected 0001", bus.mbus_ack); end
        total++; if (bus.out_id !== 2'd0) begin bad++; $display("FAIL bp_id0: got %0d expected 0", bus.out_id); end
        $display("bp: grant id=%0d", bus.out_id);
        bus.mbus_cmd[0] = 3'd0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++; if (bus.mbus_ack !== 4'b0000) begin bad++; $display("FAIL bp_stall_ack[%0d]: got %b expected 0000", c, bus.mbus_ack); end
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_stall_valid[%0d]: got %b expected 1", c, bus.out_valid); end
            total++; if (bus.out_cmd !== 3'd1 || bus.out_addr !== 32'h0000_00A0) begin bad++; $display("FAIL bp_stall_data[%0d]: got %0d/%h expected 1/000000a0", c, bus.out_cmd, bus.out_addr); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.mbus_ack !== 4'b0100) begin bad++; $display("FAIL bp_ack2: got %b expected 0100", bus.mbus_ack); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_kept: got %b expected 1", bus.out_valid); end
        total++; if (bus.out_id !== 2'd2 || bus.out_cmd !== 3'd5 || bus.out_addr !== 32'h0000_00C0) begin bad++; $display("FAIL bp_data2: got id%0d %0d/%h expected id2 5/000000c0", bus.out_id, bus.out_cmd, bus.out_addr); end
        $display("bp: grant id=%0d after ready", bus.out_id);
        clear_inputs();
    endtask

    task automatic test_withdrawal();
        do_reset();
        bus.out_ready    = 1'b0;
        bus.mbus_cmd[0]  = 3'd1;
        bus.mbus_addr[0] = 32'h0000_0010;
        @(posedge clk); #1;
        total++; if (bus.mbus_ack !== 4'b0001) begin bad++; $display("FAIL wd_ack0: got %b expected 0001", bus.mbus_ack); end
        bus.mbus_cmd[0] = 3'd0;
        @(posedge clk); #1;
        bus.mbus_cmd[3]  = 3'd4;
        bus.mbus_addr[3] = 32'h0000_0030;
        @(posedge clk); #1;
        total++; if (bus.mbus_ack !== 4'b0000) begin bad++; $display("FAIL wd_no_ack3: got %b expected 0000", bus.mbus_ack); end
        bus.mbus_cmd[3] = 3'd0;
        bus.out_ready   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            total++; if (bus.mbus_ack !== 4'b0000) begin bad++; $display("FAIL wd_ack_after[%0d]: got %b expected 0000", c, bus.mbus_ack); end
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL wd_valid[%0d]: got %b expected 0", c, bus.out_valid); end
            total++; if (bus.out_id !== 2'd0) begin bad++; $display("FAIL wd_id[%0d]: got %0d expected 0", c, bus.out_id); end
        end
        $display("withdrawal: valid=%b id=%0d", bus.out_valid, bus.out_id);
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.out_ready    = 1'b1;
        bus.mbus_cmd[2]  = 3'd3;
        bus.mbus_addr[2] = 32'h0000_2000;
        @(posedge clk); #1;
        total++; if (bus.mbus_ack !== 4'b0100) begin bad++; $display("FAIL ar_ack2: got %b expected 0100", bus.mbus_ack); end
        total++; if (bus.out_id !== 2'd2) begin bad++; $display("FAIL ar_id2: got %0d expected 2", bus.out_id); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.mbus_ack !== 4'b0000) begin bad++; $display("FAIL ar_ack_clear: got %b expected 0000", bus.mbus_ack); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid_clear: got %b expected 0", bus.out_valid); end
        total++; if (bus.out_id !== 2'd0) begin bad++; $display("FAIL ar_id_clear: got %0d expected 0", bus.out_id); end
        $display("async reset: ack=%b valid=%b id=%0d", bus.mbus_ack, bus.out_valid, bus.out_id);
        bus.mbus_cmd[2]  = 3'd0;
        bus.mbus_cmd[0]  = 3'd1;
        bus.mbus_addr[0] = 32'h0000_0100;
        bus.mbus_cmd[3]  = 3'd6;
        bus.mbus_addr[3] = 32'h0000_0300;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.mbus_ack !== 4'b0001) begin bad++; $display("FAIL ar_regrant_ack: got %b expected 0001", bus.mbus_ack); end
        total++; if (bus.out_id !== 2'd0 || bus.out_addr !== 32'h0000_0100) begin bad++; $display("FAIL ar_regrant_data: got id%0d %h expected id0 00000100", bus.out_id, bus.out_addr); end
        $display("async reset: regrant id=%0d", bus.out_id);
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_withdrawal();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
